// File: rtl/alu_pkg.sv
// Shared decode constants for the operand stage and ALU control.
// Holds datapath widths, MIPS opcode/funct encodings, the aluOp enum and
// small helpers that classify R-type funct fields.
package alu_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ANDI  = 6'd12;

  localparam logic [5:0] FN_SLL = 6'd0;
  localparam logic [5:0] FN_SRL = 6'd2;
  localparam logic [5:0] FN_SRA = 6'd3;
  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_AND   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } aluop_e;

  function automatic logic funct_supported(input logic [5:0] f);
    case (f)
      FN_SLL, FN_SRL, FN_SRA, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic funct_is_shift(input logic [5:0] f);
    return (f == FN_SLL) || (f == FN_SRL) || (f == FN_SRA);
  endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// Handshake and data bundle of the operand stage.
//   intake   : in_valid, in_ready, in_instr
//   writeback: wb_en, wb_addr, wb_data
//   ALU slot : out_valid, out_ready, input1, input2, shamt, aluOp, funct,
//              opCode, out_dest, out_wr_en, out_illegal
// master = environment (fetch + ALU + writeback), slave = the stage.
interface alu_operand_stage_if;
  import alu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_instr;

  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] input1;
  logic [DATA_W-1:0] input2;
  logic [4:0]        shamt;
  logic [1:0]        aluOp;
  logic [5:0]        funct;
  logic [5:0]        opCode;
  logic [ADDR_W-1:0] out_dest;
  logic              out_wr_en;
  logic              out_illegal;

  modport master (
    output in_valid, in_instr, wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, input1, input2, shamt, aluOp, funct, opCode,
           out_dest, out_wr_en, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, input1, input2, shamt, aluOp, funct, opCode,
           out_dest, out_wr_en, out_illegal
  );

endinterface

// File: rtl/reg_file.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, R0 hardwired to zero, asynchronous active-low reset clears all.
//   ra1/ra2 -> rd1/rd2 : combinational reads
//   we/wa/wd           : write on rising clk, ignored for wa == 0
module reg_file
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '{default: '0};
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/alu_operand_stage.sv
// Decode / operand-fetch stage feeding the 32-bit ALU.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of alu_operand_stage_if (intake, writeback,
//                registered ALU slot)
// Owns the register file, a same-cycle writeback bypass and a per-register
// pending scoreboard that stalls intake on RAW/WAW hazards.
module alu_operand_stage
  import alu_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  alu_operand_stage_if.slave bus
);

  logic [5:0]        op, fn;
  logic [4:0]        rs, rt, rd, sh;
  logic [15:0]       imm;

  assign op  = bus.in_instr[31:26];
  assign rs  = bus.in_instr[25:21];
  assign rt  = bus.in_instr[20:16];
  assign rd  = bus.in_instr[15:11];
  assign sh  = bus.in_instr[10:6];
  assign fn  = bus.in_instr[5:0];
  assign imm = bus.in_instr[15:0];

  logic [DATA_W-1:0] rf_rs, rf_rt, rs_val, rt_val;

  reg_file u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (rs),
    .ra2   (rt),
    .rd1   (rf_rs),
    .rd2   (rf_rt),
    .we    (bus.wb_en),
    .wa    (bus.wb_addr),
    .wd    (bus.wb_data)
  );

  assign rs_val = (rs == '0) ? '0 :
                  (bus.wb_en && (bus.wb_addr == rs)) ? bus.wb_data : rf_rs;
  assign rt_val = (rt == '0) ? '0 :
                  (bus.wb_en && (bus.wb_addr == rt)) ? bus.wb_data : rf_rt;

  logic              dec_legal, dec_wr, use_rs, use_rt;
  logic [ADDR_W-1:0] dec_dest;
  logic [4:0]        dec_sh;
  aluop_e            dec_aluop;
  logic [DATA_W-1:0] dec_in1, dec_in2;

  always_comb begin
    dec_legal = 1'b0;
    use_rs    = 1'b0;
    use_rt    = 1'b0;
    dec_dest  = '0;
    dec_sh    = '0;
    dec_aluop = ALUOP_ADD;
    dec_in1   = '0;
    dec_in2   = '0;
    case (op)
      OP_RTYPE: begin
        if (funct_supported(fn)) begin
          dec_legal = 1'b1;
          dec_aluop = ALUOP_FUNCT;
          dec_dest  = rd;
          dec_sh    = sh;
          use_rt    = 1'b1;
          if (funct_is_shift(fn)) begin
            dec_in1 = rt_val;
          end else begin
            use_rs  = 1'b1;
            dec_in1 = rs_val;
            dec_in2 = rt_val;
          end
        end
      end
      OP_ADDI: begin
        dec_legal = 1'b1;
        dec_aluop = ALUOP_ADD;
        dec_dest  = rt;
        use_rs    = 1'b1;
        dec_in1   = rs_val;
        dec_in2   = {{16{imm[15]}}, imm};
      end
      OP_ANDI: begin
        dec_legal = 1'b1;
        dec_aluop = ALUOP_AND;
        dec_dest  = rt;
        use_rs    = 1'b1;
        dec_in1   = rs_val;
        dec_in2   = {16'h0000, imm};
      end
      default: ;
    endcase
    dec_wr = dec_legal && (dec_dest != '0);
  end

  logic [NUM_REGS-1:0] pending;
  logic                rs_blk, rt_blk, dest_blk, hazard, ready, accept;
  logic                valid_q;

  // A pending register unblocks in the same cycle its writeback arrives.
  assign rs_blk   = pending[rs] && !(bus.wb_en && (bus.wb_addr == rs));
  assign rt_blk   = pending[rt] && !(bus.wb_en && (bus.wb_addr == rt));
  assign dest_blk = pending[dec_dest] && !(bus.wb_en && (bus.wb_addr == dec_dest));
  assign hazard   = (use_rs && rs_blk) || (use_rt && rt_blk) || (dec_wr && dest_blk);
  assign ready    = (!valid_q || bus.out_ready) && !hazard;
  assign accept   = bus.in_valid && ready;
  assign bus.in_ready = ready;

  // Clear is written before set so a new pending write dominates a
  // writeback to the same register landing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      if (bus.wb_en) pending[bus.wb_addr] <= 1'b0;
      if (accept && dec_wr) pending[dec_dest] <= 1'b1;
    end
  end

  logic [DATA_W-1:0] in1_q, in2_q;
  logic [4:0]        sh_q;
  aluop_e            aluop_q;
  logic [5:0]        fn_q, op_q;
  logic [ADDR_W-1:0] dest_q;
  logic              wr_q, ill_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      in1_q   <= '0;
      in2_q   <= '0;
      sh_q    <= '0;
      aluop_q <= ALUOP_ADD;
      fn_q    <= '0;
      op_q    <= '0;
      dest_q  <= '0;
      wr_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      in1_q   <= dec_in1;
      in2_q   <= dec_in2;
      sh_q    <= dec_sh;
      aluop_q <= dec_aluop;
      fn_q    <= fn;
      op_q    <= op;
      dest_q  <= dec_dest;
      wr_q    <= dec_wr;
      ill_q   <= !dec_legal;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.input1      = in1_q;
  assign bus.input2      = in2_q;
  assign bus.shamt       = sh_q;
  assign bus.aluOp       = aluop_q;
  assign bus.funct       = fn_q;
  assign bus.opCode      = op_q;
  assign bus.out_dest    = dest_q;
  assign bus.out_wr_en   = wr_q;
  assign bus.out_illegal = ill_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model (register array, pending flags, expected slot).
module tb_alu_operand_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_operand_stage_if bus ();

  alu_operand_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  typedef struct {
    bit        legal;
    bit [31:0] in1;
    bit [31:0] in2;
    bit [4:0]  sh;
    bit [1:0]  aop;
    bit [4:0]  dest;
    bit        wr;
    bit [31:0] srcmask;
    bit [5:0]  fn;
    bit [5:0]  op;
  } mop_t;

  bit [31:0] m_reg [32];
  bit        m_pend [32];
  bit        m_valid = 0;
  mop_t      m_slot;

  function automatic bit [31:0] m_read(input bit [4:0] a, input bit wbe,
                                       input bit [4:0] wba, input bit [31:0] wbd);
    if (a == 0) return 32'd0;
    if (wbe && wba == a) return wbd;
    return m_reg[a];
  endfunction

  function automatic mop_t m_decode(input bit [31:0] ins, input bit wbe,
                                    input bit [4:0] wba, input bit [31:0] wbd);
    mop_t d;
    bit [5:0]  op = ins[31:26];
    bit [5:0]  fn = ins[5:0];
    bit [4:0]  rs = ins[25:21];
    bit [4:0]  rt = ins[20:16];
    bit [31:0] imm = {16'd0, ins[15:0]};
    d = '{default: 0};
    d.op = op;
    d.fn = fn;
    if (op == 0 && fn inside {6'd0, 6'd2, 6'd3}) begin
      d.legal = 1; d.aop = 2; d.dest = ins[15:11]; d.sh = ins[10:6];
      d.in1 = m_read(rt, wbe, wba, wbd); d.in2 = 0;
      d.srcmask = 32'd1 << rt;
    end else if (op == 0 && fn inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd42}) begin
      d.legal = 1; d.aop = 2; d.dest = ins[15:11]; d.sh = ins[10:6];
      d.in1 = m_read(rs, wbe, wba, wbd); d.in2 = m_read(rt, wbe, wba, wbd);
      d.srcmask = (32'd1 << rs) | (32'd1 << rt);
    end else if (op == 8) begin
      d.legal = 1; d.aop = 0; d.dest = rt;
      d.in1 = m_read(rs, wbe, wba, wbd);
      d.in2 = ins[15] ? (imm | 32'hFFFF0000) : imm;
      d.srcmask = 32'd1 << rs;
    end else if (op == 12) begin
      d.legal = 1; d.aop = 1; d.dest = rt;
      d.in1 = m_read(rs, wbe, wba, wbd); d.in2 = imm;
      d.srcmask = 32'd1 << rs;
    end
    d.wr = d.legal && d.dest != 0;
    return d;
  endfunction

  function automatic bit m_hazard(input mop_t d, input bit wbe, input bit [4:0] wba);
    for (int r = 1; r < 32; r++) begin
      if ((d.srcmask[r] || (d.wr && d.dest == r)) && m_pend[r] && !(wbe && wba == r))
        return 1;
    end
    return 0;
  endfunction

  // Compare process: checks the DUT against the model, then advances the model
  // with this cycle's inputs (which are stable until after the next rising edge).
  always @(negedge clk) begin : compare
    mop_t d;
    bit   rdy;
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        m_reg[r]  = 0;
        m_pend[r] = 0;
      end
      m_valid = 0;
    end else begin
      d   = m_decode(bus.in_instr, bus.wb_en, bus.wb_addr, bus.wb_data);
      rdy = (!m_valid || bus.out_ready) && !m_hazard(d, bus.wb_en, bus.wb_addr);
      chk("m_in_ready", 32'(bus.in_ready), 32'(rdy));
      chk("m_out_valid", 32'(bus.out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("m_input1", bus.input1, m_slot.in1);
        chk("m_input2", bus.input2, m_slot.in2);
        chk("m_shamt", 32'(bus.shamt), 32'(m_slot.sh));
        chk("m_aluOp", 32'(bus.aluOp), 32'(m_slot.aop));
        chk("m_funct", 32'(bus.funct), 32'(m_slot.fn));
        chk("m_opCode", 32'(bus.opCode), 32'(m_slot.op));
        chk("m_wr_en", 32'(bus.out_wr_en), 32'(m_slot.wr));
        chk("m_illegal", 32'(bus.out_illegal), 32'(!m_slot.legal));
        if (m_slot.legal) chk("m_dest", 32'(bus.out_dest), 32'(m_slot.dest));
      end
      if (bus.in_valid && rdy) begin
        m_slot  = d;
        m_valid = 1;
      end else if (bus.out_ready) begin
        m_valid = 0;
      end
      if (bus.wb_en) begin
        if (bus.wb_addr != 0) m_reg[bus.wb_addr] = bus.wb_data;
        m_pend[bus.wb_addr] = 0;
      end
      if (bus.in_valid && rdy && d.wr) m_pend[d.dest] = 1;
    end
  end

  task automatic send(input logic [31:0] ins, input string nm);
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    chk({"accept_", nm}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  function automatic bit [31:0] rand_instr();
    bit [4:0]  rs = 5'($urandom_range(0, 7));
    bit [4:0]  rt = 5'($urandom_range(0, 7));
    bit [4:0]  rd = 5'($urandom_range(0, 7));
    bit [4:0]  sh = 5'($urandom);
    bit [15:0] imm = 16'($urandom);
    bit [5:0]  fl [8];
    bit [5:0]  x;
    fl = '{6'd0, 6'd2, 6'd3, 6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4: return {6'd0, rs, rt, rd, sh, fl[$urandom_range(0, 7)]};
      5, 6: return {6'd8, rs, rt, imm};
      7: return {6'd12, rs, rt, imm};
      8: begin
        x = 6'($urandom);
        if (x inside {6'd0, 6'd8, 6'd12}) x = 6'h23;
        return {x, rs, rt, imm};
      end
      default: begin
        x = 6'($urandom);
        if (x inside {6'd0, 6'd2, 6'd3, 6'd32, 6'd34, 6'd36, 6'd37, 6'd42}) x = 6'd1;
        return {6'd0, rs, rt, rd, sh, x};
      end
    endcase
  endfunction

  initial begin
    mop_t p;
    bit [4:0] plist [$];
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.wb_en     = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;
    bus.out_ready = 1'b1;

    // Pin the model on hand-decoded words (register file still all zero).
    p = m_decode(32'h2001FFFB, 0, 0, 0);
    chk("pin_addi_in2", p.in2, 32'hFFFFFFFB);
    chk("pin_addi_dest", 32'(p.dest), 32'd1);
    p = m_decode(32'h00011900, 1, 1, 32'd7);
    chk("pin_sll_in1", p.in1, 32'd7);
    chk("pin_sll_sh", 32'(p.sh), 32'd4);
    p = m_decode(32'h8C220000, 0, 0, 0);
    chk("pin_lw_legal", 32'(p.legal), 32'd0);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_input1", bus.input1, 32'd0);
    chk("rst_input2", bus.input2, 32'd0);
    chk("rst_aluOp", 32'(bus.aluOp), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    // ADDI $1,$0,-5
    send(32'h2001FFFB, "addi");
    @(negedge clk);
    chk("addi_valid", 32'(bus.out_valid), 32'd1);
    chk("addi_aluOp", 32'(bus.aluOp), 32'd0);
    chk("addi_in1", bus.input1, 32'd0);
    chk("addi_in2", bus.input2, 32'hFFFFFFFB);
    chk("addi_dest", 32'(bus.out_dest), 32'd1);
    chk("addi_wr", 32'(bus.out_wr_en), 32'd1);

    // ANDI $2,$1,0x8001 waits for R1, then issues on the bypassed writeback
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h30228001;
    repeat (2) begin
      @(negedge clk);
      chk("andi_stall", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.wb_en = 1'b1; bus.wb_addr = 5'd1; bus.wb_data = 32'hFFFFFFFB;
    @(negedge clk);
    chk("andi_wb_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.wb_en = 1'b0;
    @(negedge clk);
    chk("andi_in1", bus.input1, 32'hFFFFFFFB);
    chk("andi_in2", bus.input2, 32'h00008001);
    chk("andi_aluOp", 32'(bus.aluOp), 32'd1);
    chk("andi_dest", 32'(bus.out_dest), 32'd2);

    // retire R2, set R1=7
    @(posedge clk); #1;
    bus.wb_en = 1'b1; bus.wb_addr = 5'd2; bus.wb_data = 32'h1234;
    @(posedge clk); #1;
    bus.wb_addr = 5'd1; bus.wb_data = 32'd7;
    @(posedge clk); #1;
    bus.wb_en = 1'b0;

    // SLL $3,$1,4
    send(32'h00011900, "sll");
    @(negedge clk);
    chk("sll_in1", bus.input1, 32'd7);
    chk("sll_in2", bus.input2, 32'd0);
    chk("sll_shamt", 32'(bus.shamt), 32'd4);
    chk("sll_aluOp", 32'(bus.aluOp), 32'd2);
    chk("sll_funct", 32'(bus.funct), 32'd0);
    chk("sll_dest", 32'(bus.out_dest), 32'd3);
    @(posedge clk); #1;
    bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'd0;
    @(posedge clk); #1;
    bus.wb_en = 1'b0;

    // ADD $0,$1,$1 twice back-to-back
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h00210020;
    @(negedge clk);
    chk("add0_ready1", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("add0_ready2", 32'(bus.in_ready), 32'd1);
    chk("add0_wr", 32'(bus.out_wr_en), 32'd0);
    chk("add0_in1", bus.input1, 32'd7);
    chk("add0_in2", bus.input2, 32'd7);
    @(posedge clk); #1;
    bus.in_instr = 32'h8C220000;
    @(negedge clk);
    chk("add0_second_valid", 32'(bus.out_valid), 32'd1);
    chk("lw_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_instr = 32'h20040001;
    @(negedge clk);
    chk("lw_illegal", 32'(bus.out_illegal), 32'd1);
    chk("lw_wr", 32'(bus.out_wr_en), 32'd0);
    chk("lw_aluOp", 32'(bus.aluOp), 32'd0);
    chk("lw_in1", bus.input1, 32'd0);
    chk("lw_in2", bus.input2, 32'd0);
    chk("after_lw_ready", 32'(bus.in_ready), 32'd1);

    // ADDI $4 now in the slot; hold it with out_ready low
    @(posedge clk); #1;
    bus.in_instr  = 32'h00C72820;
    bus.out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_in2", bus.input2, 32'd1);
      chk("hold_dest", 32'(bus.out_dest), 32'd4);
      chk("hold_opCode", 32'(bus.opCode), 32'd8);
      chk("hold_ready", 32'(bus.in_ready), 32'd0);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in2", bus.input2, 32'd0);
    chk("midrst_opCode", 32'(bus.opCode), 32'd0);
    chk("midrst_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;

    // ADD $5,$1,$3: registers must read back as zero after reset
    send(32'h00232820, "postrst");
    @(negedge clk);
    chk("postrst_in1", bus.input1, 32'd0);
    chk("postrst_in2", bus.input2, 32'd0);
    chk("postrst_dest", 32'(bus.out_dest), 32'd5);

    // randomized traffic
    repeat (3000) begin
      @(posedge clk); #1;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_instr  = rand_instr();
      bus.out_ready = ($urandom_range(0, 3) != 0);
      plist.delete();
      for (int r = 1; r < 32; r++) if (m_pend[r]) plist.push_back(5'(r));
      case ($urandom_range(0, 3))
        0, 1: begin
          if (plist.size() != 0) begin
            bus.wb_en   = 1'b1;
            bus.wb_addr = plist[$urandom_range(0, plist.size() - 1)];
            bus.wb_data = $urandom;
          end else begin
            bus.wb_en = 1'b0;
          end
        end
        2: begin
          bus.wb_en   = 1'b1;
          bus.wb_addr = 5'd0;
          bus.wb_data = $urandom;
        end
        default: bus.wb_en = 1'b0;
      endcase
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.wb_en    = 1'b0;
    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
